ntt_dout_capture: RTL and testbench

- Downstream stage of NTTN: consumes the serial result burst on `dout` that follows a `done` pulse, and buffers all RING_SIZE coefficients in an internal RAM.
- Replays the buffered coefficients on a valid/ready stream with backpressure, so consumers (pointwise multiplier, DMA) need not keep pace with NTTN's fixed-rate burst.
- Flags a sticky overflow if NTTN finishes another transform before the buffer has drained.

---
 rtl/ntt_dout_capture_pkg.sv | 46 ++++
 rtl/ntt_cap_ram.sv | 47 ++++
 rtl/ntt_dout_capture.sv | 208 ++++++++++++++++++++
 tb/tb_ntt_dout_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_dout_capture_pkg.sv
// ----------------------------------------------------------------------------
// ntt_dout_capture_pkg
// Shared definitions for the NTTN result-capture block: default coefficient
// width and ring depth, the capture FSM state set, and the index bit-reverse
// helper.
// Configuration macros:
//   DATA_SIZE_ARB      - coefficient width (defaults to 16 when undefined)
//   RING_DEPTH         - log2 of coefficient count (defaults to 4)
//   NTT_CAP_BITREV_EN  - consumed by ntt_dout_capture (bit-reversed drain)
// ----------------------------------------------------------------------------
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif
`ifndef RING_DEPTH
`define RING_DEPTH 4
`endif

package ntt_dout_capture_pkg;

    localparam int PKG_DATA_W     = `DATA_SIZE_ARB;
    localparam int PKG_RING_DEPTH = `RING_DEPTH;
    localparam int PKG_RING_SIZE  = 1 << PKG_RING_DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } cap_state_e;

    // Reverse the low 'width' bits of 'value'; bits above 'width' return 0.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                                input int          width);
        logic [31:0] result;
        result = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                result[width-1-i] = value[i];
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ntt_cap_ram.sv
// ----------------------------------------------------------------------------
// ntt_cap_ram
// Simple dual-port coefficient buffer: synchronous write, registered read
// with read enable (the read register holds its value while i_re is low),
// no reset on contents or read register.
// Ports:
//   clk      - clock, rising edge
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_re     - read enable (loads the read register)
//   i_raddr  - read address
//   o_rdata  - registered read data, valid the cycle after i_re
// ----------------------------------------------------------------------------
module ntt_cap_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port; the register doubles as the stream's prefetch stage.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ntt_dout_capture.sv
// ----------------------------------------------------------------------------
// ntt_dout_capture
// Captures the RING_SIZE-word result burst NTTN emits after 'done', then
// replays it on a valid/ready stream with backpressure. A done pulse that
// arrives while a frame is still in flight sets a sticky overflow flag and
// is otherwise ignored.
// Configuration macro:
//   NTT_CAP_BITREV_EN - when defined, the drain reads bit-reversed addresses
//                       and m_index carries the bit-reversed index.
// Ports:
//   clk, reset      - clock (rising edge), asynchronous active-high reset
//   done_i, dout_i  - NTTN done pulse and serial result data
//   m_valid/m_ready - output stream handshake
//   m_data, m_index - output coefficient and its index
//   m_last          - marks the final word of a frame
//   busy            - block is not idle
//   overflow        - sticky, cleared only by reset
// ----------------------------------------------------------------------------
module ntt_dout_capture
    import ntt_dout_capture_pkg::*;
#(
    parameter int DATA_W     = PKG_DATA_W,
    parameter int RING_DEPTH = PKG_RING_DEPTH,
    parameter int CAP_DELAY  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  done_i,
    input  logic [DATA_W-1:0]     dout_i,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic [RING_DEPTH-1:0] m_index,
    output logic                  m_last,
    output logic                  busy,
    output logic                  overflow
);

    localparam int                    RING_SIZE = 1 << RING_DEPTH;
    localparam logic [RING_DEPTH-1:0] PTR_LAST  = RING_DEPTH'(RING_SIZE - 1);
    // WAIT lasts CAP_DELAY-1 cycles; delays of 0 and 1 skip WAIT entirely so
    // the first word is taken the cycle after done.
    localparam logic [2:0]            DLY_LAST  = (CAP_DELAY >= 2) ? 3'(CAP_DELAY - 2) : 3'd0;
    localparam cap_state_e            ST_START  = (CAP_DELAY >= 2) ? ST_WAIT : ST_CAPTURE;

    cap_state_e            r_state;
    cap_state_e            w_next_state;
    logic [2:0]            r_dly_cnt;
    logic [RING_DEPTH-1:0] r_wr_ptr;
    logic [RING_DEPTH-1:0] r_rd_cnt;
    logic                  r_rd_all;
    logic                  r_m_valid;
    logic [RING_DEPTH-1:0] r_m_index;
    logic                  r_m_last;
    logic                  r_overflow;

    logic                  w_we;
    logic                  w_set_ovf;
    logic                  w_xfer;
    logic                  w_final_xfer;
    logic                  w_load;
    logic [RING_DEPTH-1:0] w_rd_addr;
    logic [DATA_W-1:0]     w_ram_q;

    assign w_xfer       = r_m_valid && m_ready;
    assign w_final_xfer = w_xfer && r_m_last;
    // Fetch the next word whenever the output slot is empty or being emptied.
    assign w_load       = (r_state == ST_DRAIN) && !r_rd_all && (!r_m_valid || m_ready);

`ifdef NTT_CAP_BITREV_EN
    assign w_rd_addr = RING_DEPTH'(bit_reverse(32'(r_rd_cnt), RING_DEPTH));
`else
    assign w_rd_addr = r_rd_cnt;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state, capture write enable and overflow detection.
    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_set_ovf    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (done_i) begin
                    w_next_state = ST_START;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_set_ovf = done_i;
                if (r_dly_cnt == DLY_LAST) begin
                    w_next_state = ST_CAPTURE;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                w_we      = 1'b1;
                w_set_ovf = done_i;
                if (r_wr_ptr == PTR_LAST) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                // A done coinciding with the final handshake starts a new frame.
                if (w_final_xfer) begin
                    if (done_i) begin
                        w_next_state = ST_START;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_set_ovf    = done_i;
                    w_next_state = ST_DRAIN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Delay counter, write pointer and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dly_cnt  <= 3'd0;
            r_wr_ptr   <= {RING_DEPTH{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (r_state == ST_WAIT) begin
                r_dly_cnt <= r_dly_cnt + 3'd1;
            end else begin
                r_dly_cnt <= 3'd0;
            end
            // Wraps to zero on the last word, ready for the next frame.
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + {{(RING_DEPTH-1){1'b0}}, 1'b1};
            end
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Drain counter and output stage: index/last are registered alongside the
    // RAM read register so they stay aligned with the word they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_cnt  <= {RING_DEPTH{1'b0}};
            r_rd_all  <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_index <= {RING_DEPTH{1'b0}};
            r_m_last  <= 1'b0;
        end else if (w_load) begin
            r_rd_cnt  <= r_rd_cnt + {{(RING_DEPTH-1){1'b0}}, 1'b1};
            r_rd_all  <= (r_rd_cnt == PTR_LAST);
            r_m_valid <= 1'b1;
            r_m_index <= w_rd_addr;
            r_m_last  <= (r_rd_cnt == PTR_LAST);
        end else if (w_xfer) begin
            r_rd_all  <= r_final_clear(w_final_xfer, r_rd_all);
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    // Clears the "all issued" flag once the final word has been handed off.
    function automatic logic r_final_clear(input logic final_xfer, input logic rd_all);
        if (final_xfer) begin
            return 1'b0;
        end else begin
            return rd_all;
        end
    endfunction

    ntt_cap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (RING_DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (dout_i),
        .i_re    (w_load),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    // The RAM read register is not reset, so data is forced to zero when idle.
    assign m_data   = r_m_valid ? w_ram_q : {DATA_W{1'b0}};
    assign m_valid  = r_m_valid;
    assign m_index  = r_m_index;
    assign m_last   = r_m_last;
    assign busy     = (r_state != ST_IDLE);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ntt_dout_capture.sv
module tb_ntt_dout_capture;

    localparam int DW = 16;
    localparam int RD = 4;
    localparam int RS = 1 << RD;

    logic          clk = 1'b0;
    logic          reset;
    logic          done_i;
    logic [DW-1:0] dout_i;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [RD-1:0] m_index;
    logic          m_last;
    logic          busy;
    logic          overflow;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int t_done  = 0;

    // Reference model: captured words and the expected output order.
    int words    [RS];
    int exp_data [RS];
    int exp_idx  [RS];

    ntt_dout_capture #(.DATA_W(DW), .RING_DEPTH(RD), .CAP_DELAY(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .done_i   (done_i),
        .dout_i   (dout_i),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_index  (m_index),
        .m_last   (m_last),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int rev_index(input int v);
        int r = 0;
        for (int b = 0; b < RD; b++) begin
            if (((v >> b) & 1) == 1) r += (1 << (RD - 1 - b));
        end
        return r;
    endfunction

    task automatic build_model();
        for (int j = 0; j < RS; j++) begin
`ifdef NTT_CAP_BITREV_EN
            exp_idx[j] = rev_index(j);
`else
            exp_idx[j] = j;
`endif
            exp_data[j] = words[exp_idx[j]];
        end
    endtask

    task automatic pulse_done();
        t_done = cyc;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    // Feed one burst, one word per cycle; optionally pulse done at word ovf_at.
    task automatic capture_words(input int base, input bit rnd, input int ovf_at);
        for (int k = 0; k < RS; k++) begin
            words[k] = rnd ? int'($urandom_range(0, 65535)) : base + k;
            dout_i   = DW'(words[k]);
            done_i   = (k == ovf_at);
            if (k == 0) chk("busy_capture", busy, 1);
            chk("valid_in_capture", m_valid, 0);
            tick();
        end
        done_i = 1'b0;
        dout_i = '0;
        build_model();
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic drain_frame(input int mode, input bit done_last, input int rst_at);
        int  j     = 0;
        int  guard = 0;
        int  ph    = 0;
        bit  rdy;
        bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        chk("valid_lat_minus1", m_valid, 0);
        tick();
        chk("valid_lat", m_valid, 1);
        chk("first_valid_cycle", cyc - t_done, RS + 2);
        while (j < RS && guard < 300) begin
            guard++;
            if (j == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_valid", m_valid, 0);
                chk("rst_busy", busy, 0);
                tick();
                reset = 1'b0;
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[ph % 4];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ph++;
            m_ready = rdy;
            chk("m_valid", m_valid, 1);
            chk("m_data", m_data, exp_data[j]);
            chk("m_index", m_index, exp_idx[j]);
            chk("m_last", m_last, (j == RS - 1));
            if (rdy) begin
                if (j == RS - 1 && done_last) begin
                    t_done = cyc;
                    done_i = 1'b1;
                end
                j++;
            end
            tick();
            done_i = 1'b0;
        end
        chk("drain_count", j, RS);
        chk("valid_drop", m_valid, 0);
        chk("busy_after_drain", busy, done_last);
        m_ready = 1'b1;
    endtask

    initial begin
        reset   = 1'b1;
        done_i  = 1'b0;
        dout_i  = '0;
        m_ready = 1'b1;
        repeat (3) tick();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_index", m_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
        while (cyc < 10) tick();

        // Basic frame 100+k, always ready.
        pulse_done();
        capture_words(100, 1'b0, -1);
        drain_frame(0, 1'b0, -1);
        chk("ovf_basic", overflow, 0);

        // Backpressure with ready pattern 1,0,0,1 on random data.
        tick();
        pulse_done();
        capture_words(0, 1'b1, -1);
        drain_frame(1, 1'b0, -1);

        // Overflow: extra done 5 words into capture.
        tick();
        pulse_done();
        capture_words(100, 1'b0, 5);
        chk("ovf_set", overflow, 1);
        drain_frame(0, 1'b0, -1);
        for (int i = 0; i < 20; i++) begin
            if (m_valid !== 1'b0 || busy !== 1'b0) chk("no_second_frame", {m_valid, busy}, 0);
            tick();
        end
        chk("idle_after_ovf", busy, 0);
        chk("ovf_sticky", overflow, 1);

        // Reset to clear overflow, then back-to-back frames.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ovf_cleared", overflow, 0);
        tick();
        pulse_done();
        capture_words(0, 1'b1, -1);
        drain_frame(0, 1'b1, -1);
        capture_words(200, 1'b0, -1);
        drain_frame(2, 1'b0, -1);
        chk("ovf_back_to_back", overflow, 0);

        // Reset mid-drain after word 7, then a fresh frame 300+k.
        tick();
        pulse_done();
        capture_words(0, 1'b1, -1);
        drain_frame(0, 1'b0, 8);
        pulse_done();
        capture_words(300, 1'b0, -1);
        drain_frame(0, 1'b0, -1);

        // Random data under random backpressure.
        for (int r = 0; r < 2; r++) begin
            tick();
            pulse_done();
            capture_words(0, 1'b1, -1);
            drain_frame(2, 1'b0, -1);
        end
        chk("ovf_final", overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
